// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 16-lane SDF FFT datapath blocks.
//   LANES         : number of complex samples carried per beat
//   pair_state_e  : state encoding of the butterfly pair aligner
//   idx_width()   : width of a beat index over n beats, never below 1 bit
// The per-beat lane array type depends on each module's WIDTH parameter, so
// modules declare it locally as  logic signed [WIDTH-1:0] x [LANES].
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int LANES = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAIR
    } pair_state_e;

    // A 1-beat half-frame still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bfly_pair_align_delay.sv
// ---------------------------------------------------------------------------
// bfly_pair_align_delay
// 16-lane complex delay line, DEPTH beats deep, advancing only when shift=1.
// The tail is the beat written DEPTH shifts ago.
//   clk, rstn        : clock, asynchronous active-low reset (clears contents)
//   shift            : advance the line and capture din this cycle
//   din_re / din_im  : incoming beat, LANES signed samples each
//   tail_re/tail_im  : oldest beat held in the line
// ---------------------------------------------------------------------------
module bfly_pair_align_delay
    import fft_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    shift,
    input  logic signed [WIDTH-1:0] din_re  [0:LANES-1],
    input  logic signed [WIDTH-1:0] din_im  [0:LANES-1],
    output logic signed [WIDTH-1:0] tail_re [0:LANES-1],
    output logic signed [WIDTH-1:0] tail_im [0:LANES-1]
);

    logic signed [WIDTH-1:0] mem_re [DEPTH][LANES];
    logic signed [WIDTH-1:0] mem_im [DEPTH][LANES];

    // Slot 0 takes the new beat; every other slot takes its predecessor.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int l = 0; l < LANES; l++) begin
                    mem_re[d][l] <= '0;
                    mem_im[d][l] <= '0;
                end
            end
        end else if (shift) begin
            for (int l = 0; l < LANES; l++) begin
                mem_re[0][l] <= din_re[l];
                mem_im[0][l] <= din_im[l];
            end
            for (int d = 1; d < DEPTH; d++) begin
                for (int l = 0; l < LANES; l++) begin
                    mem_re[d][l] <= mem_re[d-1][l];
                    mem_im[d][l] <= mem_im[d-1][l];
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            tail_re[l] = mem_re[DEPTH-1][l];
            tail_im[l] = mem_im[DEPTH-1][l];
        end
    end

endmodule

// File: rtl/bfly_pair_align.sv
// ---------------------------------------------------------------------------
// bfly_pair_align
// Aligns the operands of a radix-2 SDF butterfly. The first N beats of each
// 2N-beat frame are held in a delay line; every beat of the second half is
// emitted one cycle later together with the beat N positions earlier.
// N = MEM_DEPTH/16; MEM_DEPTH must be a multiple of 16 and at least 16.
//   clk, rstn             : clock, asynchronous active-low reset
//   din_re / din_im       : incoming 16-lane beat
//   valid, sof            : beat qualifier, start of frame (with valid only)
//   dout_a_re / dout_a_im : delayed operand x[k]
//   dout_b_re / dout_b_im : current operand x[k+N]
//   dout_valid            : one-cycle pulse per emitted pair
//   dout_idx              : k within the half-frame, for twiddle addressing
//   sof_err               : one-cycle pulse when sof forced a mid-frame resync
// Output data holds its last value while dout_valid is low.
// ---------------------------------------------------------------------------
module bfly_pair_align
    import fft_pkg::*;
#(
    parameter  int WIDTH     = 9,
    parameter  int MEM_DEPTH = 256,
    localparam int N         = MEM_DEPTH / 16,
    localparam int IDXW      = idx_width(MEM_DEPTH / 16)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [WIDTH-1:0] din_re    [0:LANES-1],
    input  logic signed [WIDTH-1:0] din_im    [0:LANES-1],
    input  logic                    valid,
    input  logic                    sof,
    output logic signed [WIDTH-1:0] dout_a_re [0:LANES-1],
    output logic signed [WIDTH-1:0] dout_a_im [0:LANES-1],
    output logic signed [WIDTH-1:0] dout_b_re [0:LANES-1],
    output logic signed [WIDTH-1:0] dout_b_im [0:LANES-1],
    output logic                    dout_valid,
    output logic [IDXW-1:0]         dout_idx,
    output logic                    sof_err
);

    localparam int CNTW = $clog2(2 * N);

    localparam logic [CNTW-1:0] ONE_C  = CNTW'(1);
    localparam logic [CNTW-1:0] N_C    = CNTW'(N);
    localparam logic [CNTW-1:0] LAST_C = CNTW'(2 * N - 1);

    // Position 1 is already in the second half when N = 1.
    localparam pair_state_e AFTER_BEAT0 = (ONE_C < N_C) ? FILL : PAIR;

    pair_state_e             state_q, state_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic                    shift_en;
    logic                    pair_fire;
    logic                    resync;
    logic signed [WIDTH-1:0] tail_re [0:LANES-1];
    logic signed [WIDTH-1:0] tail_im [0:LANES-1];

    bfly_pair_align_delay #(
        .WIDTH (WIDTH),
        .DEPTH (N)
    ) u_delay (
        .clk     (clk),
        .rstn    (rstn),
        .shift   (shift_en),
        .din_re  (din_re),
        .din_im  (din_im),
        .tail_re (tail_re),
        .tail_im (tail_im)
    );

    // State and beat position only move on accepted beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Accept logic. Outside IDLE every valid beat is shifted in, including
    // second-half beats whose contents are never read back. A sof at any
    // position other than 0 restarts the frame with this beat as beat 0;
    // at position 0 it simply confirms the boundary the counter implied.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        pair_fire = 1'b0;
        resync    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid && sof) begin
                    shift_en = 1'b1;
                    cnt_d    = ONE_C;
                    state_d  = AFTER_BEAT0;
                end
            end
            FILL, PAIR: begin
                if (valid) begin
                    shift_en = 1'b1;
                    if (sof && (cnt_q != '0)) begin
                        resync  = 1'b1;
                        cnt_d   = ONE_C;
                        state_d = AFTER_BEAT0;
                    end else begin
                        pair_fire = (state_q == PAIR);
                        cnt_d     = (cnt_q == LAST_C) ? '0 : cnt_q + ONE_C;
                        state_d   = (cnt_d < N_C) ? FILL : PAIR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pair registers: the tail still holds beat k because the line only
    // advances at this same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int l = 0; l < LANES; l++) begin
                dout_a_re[l] <= '0;
                dout_a_im[l] <= '0;
                dout_b_re[l] <= '0;
                dout_b_im[l] <= '0;
            end
            dout_valid <= 1'b0;
            dout_idx   <= '0;
            sof_err    <= 1'b0;
        end else begin
            dout_valid <= pair_fire;
            sof_err    <= resync;
            if (pair_fire) begin
                for (int l = 0; l < LANES; l++) begin
                    dout_a_re[l] <= tail_re[l];
                    dout_a_im[l] <= tail_im[l];
                    dout_b_re[l] <= din_re[l];
                    dout_b_im[l] <= din_im[l];
                end
                dout_idx <= IDXW'(cnt_q - N_C);
            end
        end
    end

endmodule

// File: tb/tb_bfly_pair_align.sv
// ---------------------------------------------------------------------------
// tb_bfly_pair_align
// Self-checking bench for bfly_pair_align with MEM_DEPTH = 32 (N = 2).
// The reference model tracks the position of each accepted beat within its
// frame and, for second-half positions, predicts the pair (frame[p-N], beat).
// ---------------------------------------------------------------------------
module tb_bfly_pair_align;

    localparam int WIDTH     = 9;
    localparam int MEM_DEPTH = 32;
    localparam int N         = 2;
    localparam int LANES     = 16;
    localparam int IDXW      = 1;
    localparam int WW        = 4 * LANES * WIDTH + IDXW + 2;

    logic                    clk;
    logic                    rstn;
    logic signed [WIDTH-1:0] din_re    [0:LANES-1];
    logic signed [WIDTH-1:0] din_im    [0:LANES-1];
    logic                    valid;
    logic                    sof;
    logic signed [WIDTH-1:0] dout_a_re [0:LANES-1];
    logic signed [WIDTH-1:0] dout_a_im [0:LANES-1];
    logic signed [WIDTH-1:0] dout_b_re [0:LANES-1];
    logic signed [WIDTH-1:0] dout_b_im [0:LANES-1];
    logic                    dout_valid;
    logic [IDXW-1:0]         dout_idx;
    logic                    sof_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int                      pos;
    logic signed [WIDTH-1:0] frame_re [2*N][LANES];
    logic signed [WIDTH-1:0] frame_im [2*N][LANES];
    logic signed [WIDTH-1:0] exp_a_re [LANES];
    logic signed [WIDTH-1:0] exp_a_im [LANES];
    logic signed [WIDTH-1:0] exp_b_re [LANES];
    logic signed [WIDTH-1:0] exp_b_im [LANES];
    logic                    exp_valid;
    logic                    exp_err;
    logic [IDXW-1:0]         exp_idx;
    logic signed [WIDTH-1:0] cur_re [LANES];
    logic signed [WIDTH-1:0] cur_im [LANES];

    bfly_pair_align #(
        .WIDTH     (WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_re     (din_re),
        .din_im     (din_im),
        .valid      (valid),
        .sof        (sof),
        .dout_a_re  (dout_a_re),
        .dout_a_im  (dout_a_im),
        .dout_b_re  (dout_b_re),
        .dout_b_im  (dout_b_im),
        .dout_valid (dout_valid),
        .dout_idx   (dout_idx),
        .sof_err    (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [WW-1:0] pack_dut();
        logic [WW-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++) begin
            w[l*WIDTH +: WIDTH]             = dout_a_re[l];
            w[(LANES+l)*WIDTH +: WIDTH]     = dout_a_im[l];
            w[(2*LANES+l)*WIDTH +: WIDTH]   = dout_b_re[l];
            w[(3*LANES+l)*WIDTH +: WIDTH]   = dout_b_im[l];
        end
        w[4*LANES*WIDTH +: IDXW] = dout_idx;
        w[WW-2] = sof_err;
        w[WW-1] = dout_valid;
        return w;
    endfunction

    function automatic logic [WW-1:0] pack_exp();
        logic [WW-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++) begin
            w[l*WIDTH +: WIDTH]             = exp_a_re[l];
            w[(LANES+l)*WIDTH +: WIDTH]     = exp_a_im[l];
            w[(2*LANES+l)*WIDTH +: WIDTH]   = exp_b_re[l];
            w[(3*LANES+l)*WIDTH +: WIDTH]   = exp_b_im[l];
        end
        w[4*LANES*WIDTH +: IDXW] = exp_idx;
        w[WW-2] = exp_err;
        w[WW-1] = exp_valid;
        return w;
    endfunction

    task automatic model_reset();
        pos = -1;
        for (int l = 0; l < LANES; l++) begin
            exp_a_re[l] = '0;
            exp_a_im[l] = '0;
            exp_b_re[l] = '0;
            exp_b_im[l] = '0;
        end
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_idx   = '0;
    endtask

    task automatic set_pattern(input int b);
        for (int l = 0; l < LANES; l++) begin
            cur_re[l] = WIDTH'(b * 16 + l);
            cur_im[l] = WIDTH'(-(b * 16 + l));
        end
    endtask

    task automatic set_random();
        for (int l = 0; l < LANES; l++) begin
            cur_re[l] = WIDTH'($urandom);
            cur_im[l] = WIDTH'($urandom);
        end
    endtask

    // Drives one cycle of stimulus from cur_*, updates the model's
    // expectation for the cycle after the edge, and returns at edge + 1.
    task automatic cycle(input bit v, input bit s);
        valid = v;
        sof   = s;
        for (int l = 0; l < LANES; l++) begin
            din_re[l] = cur_re[l];
            din_im[l] = cur_im[l];
        end
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (v) begin
            if (pos < 0) begin
                if (s) begin
                    for (int l = 0; l < LANES; l++) begin
                        frame_re[0][l] = cur_re[l];
                        frame_im[0][l] = cur_im[l];
                    end
                    pos = 1;
                end
            end else if (s && pos != 0) begin
                exp_err = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    frame_re[0][l] = cur_re[l];
                    frame_im[0][l] = cur_im[l];
                end
                pos = 1;
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    frame_re[pos][l] = cur_re[l];
                    frame_im[pos][l] = cur_im[l];
                end
                if (pos >= N) begin
                    for (int l = 0; l < LANES; l++) begin
                        exp_a_re[l] = frame_re[pos-N][l];
                        exp_a_im[l] = frame_im[pos-N][l];
                        exp_b_re[l] = cur_re[l];
                        exp_b_im[l] = cur_im[l];
                    end
                    exp_idx   = IDXW'(pos - N);
                    exp_valid = 1'b1;
                end
                pos = (pos + 1) % (2 * N);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        sof   = 1'b0;
        rstn  = 1'b0;
        model_reset();
        #3;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        set_random();
        for (int l = 0; l < LANES; l++) begin
            din_re[l] = cur_re[l];
            din_im[l] = cur_im[l];
        end
        valid = 1'b1;
        sof   = 1'b1;
        rstn  = 1'b0;
        model_reset();
        #2;
        compared++;
        if (pack_dut() !== pack_exp()) begin
            mismatched++;
            $display("[TB] FAIL reset_state actual=%h required=%h", pack_dut(), pack_exp());
        end
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (pack_dut() !== pack_exp()) begin
            mismatched++;
            $display("[TB] FAIL reset_held actual=%h required=%h", pack_dut(), pack_exp());
        end
        valid = 1'b0;
        sof   = 1'b0;
        rstn  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        int pulses;
        pulses = 0;
        do_reset();
        for (int b = 0; b < 5; b++) begin
            set_pattern(b);
            cycle(b < 4, b == 0);
            pulses += int'(dout_valid);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL single_frame beat %0d actual=%h required=%h", b, pack_dut(), pack_exp());
            end
            if (b == 2) begin
                compared++;
                if (dout_a_re[5] !== 9'sd5 || dout_b_re[5] !== 9'sd37 || dout_idx !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL single_frame pair0 actual a=%0d b=%0d idx=%0d required a=5 b=37 idx=0",
                             dout_a_re[5], dout_b_re[5], dout_idx);
                end
            end
            if (b == 3) begin
                compared++;
                if (dout_a_re[0] !== 9'sd16 || dout_b_re[0] !== 9'sd48 || dout_idx !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL single_frame pair1 actual a=%0d b=%0d idx=%0d required a=16 b=48 idx=1",
                             dout_a_re[0], dout_b_re[0], dout_idx);
                end
            end
        end
        compared++;
        if (pulses !== 2) begin
            mismatched++;
            $display("[TB] FAIL single_frame pulses actual=%0d required=2", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int errs;
        pulses = 0;
        errs   = 0;
        do_reset();
        for (int b = 0; b < 9; b++) begin
            set_pattern(b);
            cycle(b < 8, b == 0);
            pulses += int'(dout_valid);
            errs   += int'(sof_err);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL back_to_back beat %0d actual=%h required=%h", b, pack_dut(), pack_exp());
            end
        end
        compared++;
        if (pulses !== 4 || errs !== 0) begin
            mismatched++;
            $display("[TB] FAIL back_to_back counts actual pulses=%0d errs=%0d required pulses=4 errs=0", pulses, errs);
        end
    endtask

    task automatic test_valid_gaps();
        int pulses;
        pulses = 0;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            set_pattern(b);
            cycle(1'b1, b == 0);
            pulses += int'(dout_valid);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL valid_gaps beat %0d actual=%h required=%h", b, pack_dut(), pack_exp());
            end
            for (int g = 0; g < 3; g++) begin
                set_random();
                cycle(1'b0, g == 1);
                pulses += int'(dout_valid);
                compared++;
                if (pack_dut() !== pack_exp()) begin
                    mismatched++;
                    $display("[TB] FAIL valid_gaps gap %0d.%0d actual=%h required=%h", b, g, pack_dut(), pack_exp());
                end
            end
        end
        compared++;
        if (pulses !== 2 || dout_a_re[0] !== 9'sd16 || dout_b_re[0] !== 9'sd48) begin
            mismatched++;
            $display("[TB] FAIL valid_gaps final actual pulses=%0d a=%0d b=%0d required pulses=2 a=16 b=48",
                     pulses, dout_a_re[0], dout_b_re[0]);
        end
    endtask

    task automatic test_mid_frame_sof();
        int errs;
        int pulses;
        errs   = 0;
        pulses = 0;
        do_reset();
        for (int b = 0; b < 5; b++) begin
            set_pattern(b);
            cycle(1'b1, b <= 1);
            errs   += int'(sof_err);
            pulses += int'(dout_valid);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL mid_sof beat %0d actual=%h required=%h", b, pack_dut(), pack_exp());
            end
            if (b == 3) begin
                compared++;
                if (dout_valid !== 1'b1 || dout_a_re[0] !== 9'sd16 || dout_a_im[0] !== -9'sd16) begin
                    mismatched++;
                    $display("[TB] FAIL mid_sof resync_pair actual v=%0b a=%0d required v=1 a=16",
                             dout_valid, dout_a_re[0]);
                end
            end
        end
        compared++;
        if (errs !== 1 || pulses !== 2) begin
            mismatched++;
            $display("[TB] FAIL mid_sof counts actual errs=%0d pulses=%0d required errs=1 pulses=2", errs, pulses);
        end
    endtask

    task automatic test_pre_sof();
        int pulses;
        pulses = 0;
        do_reset();
        for (int b = 10; b < 15; b++) begin
            set_pattern(b);
            cycle(1'b1, 1'b0);
            pulses += int'(dout_valid);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL pre_sof ignored %0d actual=%h required=%h", b, pack_dut(), pack_exp());
            end
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("[TB] FAIL pre_sof pulses actual=%0d required=0", pulses);
        end
        for (int b = 0; b < 4; b++) begin
            set_pattern(b);
            cycle(1'b1, b == 0);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL pre_sof frame beat %0d actual=%h required=%h", b, pack_dut(), pack_exp());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            set_pattern(b);
            cycle(1'b1, b == 0);
        end
        compared++;
        if (dout_valid !== 1'b1 || dout_b_re[5] !== 9'sd37) begin
            mismatched++;
            $display("[TB] FAIL reset_mid pre actual v=%0b b=%0d required v=1 b=37", dout_valid, dout_b_re[5]);
        end
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        compared++;
        if (pack_dut() !== pack_exp()) begin
            mismatched++;
            $display("[TB] FAIL reset_mid async actual=%h required=%h", pack_dut(), pack_exp());
        end
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int b = 3; b < 6; b++) begin
            set_pattern(b);
            cycle(1'b1, 1'b0);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL reset_mid nosof %0d actual=%h required=%h", b, pack_dut(), pack_exp());
            end
        end
        for (int b = 6; b < 10; b++) begin
            set_pattern(b);
            cycle(1'b1, b == 6);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL reset_mid frame %0d actual=%h required=%h", b, pack_dut(), pack_exp());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_random();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            compared++;
            if (pack_dut() !== pack_exp()) begin
                mismatched++;
                $display("[TB] FAIL random cycle %0d actual=%h required=%h", c, pack_dut(), pack_exp());
            end
        end
    endtask

    initial begin
        rstn  = 1'b0;
        valid = 1'b0;
        sof   = 1'b0;
        set_random();
        for (int l = 0; l < LANES; l++) begin
            din_re[l] = cur_re[l];
            din_im[l] = cur_im[l];
        end
        model_reset();
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_valid_gaps();
        test_mid_frame_sof();
        test_pre_sof();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
